// File: rtl/sr_ctrl_if.sv
// sr_ctrl_if: request/grant/flag bundle for sr_ctrl; alu_mask exists only under SRCTRL_ALU_MASK_EN
interface sr_ctrl_if;
  logic alu_req, alu_gnt, ld_req, ld_gnt, ie_req, ix_req, ie_ack, ix_ack;
  logic [3:0] alu_flags, ld_flags, sr_in;
`ifdef SRCTRL_ALU_MASK_EN
  logic [3:0] alu_mask;
`endif
  logic sr_v, sr_n, sr_z, sr_c, sr_ws, busy, stk_full, stk_empty, err_clr;
  logic [1:0] stk_err;
`ifdef SRCTRL_ALU_MASK_EN
  modport master (
    output alu_req, alu_flags, alu_mask, ld_req, ld_flags, ie_req, ix_req, sr_in, err_clr,
    input alu_gnt, ld_gnt, ie_ack, ix_ack, sr_v, sr_n, sr_z, sr_c, sr_ws, busy, stk_full, stk_empty, stk_err
  );
  modport slave (
    input alu_req, alu_flags, alu_mask, ld_req, ld_flags, ie_req, ix_req, sr_in, err_clr,
    output alu_gnt, ld_gnt, ie_ack, ix_ack, sr_v, sr_n, sr_z, sr_c, sr_ws, busy, stk_full, stk_empty, stk_err
  );
`else
  modport master (
    output alu_req, alu_flags, ld_req, ld_flags, ie_req, ix_req, sr_in, err_clr,
    input alu_gnt, ld_gnt, ie_ack, ix_ack, sr_v, sr_n, sr_z, sr_c, sr_ws, busy, stk_full, stk_empty, stk_err
  );
  modport slave (
    input alu_req, alu_flags, ld_req, ld_flags, ie_req, ix_req, sr_in, err_clr,
    output alu_gnt, ld_gnt, ie_ack, ix_ack, sr_v, sr_n, sr_z, sr_c, sr_ws, busy, stk_full, stk_empty, stk_err
  );
`endif
endinterface

// File: rtl/sr_ctrl.sv
// sr_ctrl: status register write arbiter with interrupt shadow stack; SRCTRL_ALU_MASK_EN enables per-flag ALU write mask
module sr_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTRW = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  sr_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SAVE, CLEAR, RESTORE, ACK} state_t;
  localparam logic [PTRW:0] PMAX = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0] ONE = (PTRW+1)'(1);
  state_t state, state_nxt;
  logic [PTRW:0] ptr, ptr_nxt;
  logic [PTRW-1:0] top_idx;
  logic [3:0] stack [DEPTH];
  logic [3:0] sr_q, sr_nxt, alu_val;
  logic ws_q, ws_nxt, ie_ack_q, ie_ack_nxt, ix_ack_q, ix_ack_nxt, push;
  logic [1:0] err_q, err_set;
  logic ie, ix, idle, ld_win, alu_win;
  assign idle = state == IDLE;
  assign ix = bus.ix_req & ~ix_ack_q;
  assign ie = bus.ie_req & ~ie_ack_q;
  assign ld_win = idle & ~ix & ~ie & bus.ld_req;
  assign alu_win = idle & ~ix & ~ie & ~bus.ld_req & bus.alu_req;
  assign top_idx = ptr[PTRW-1:0] - PTRW'(1);
`ifdef SRCTRL_ALU_MASK_EN
  assign alu_val = (bus.alu_flags & bus.alu_mask) | (bus.sr_in & ~bus.alu_mask);
`else
  assign alu_val = bus.alu_flags;
`endif
  assign bus.alu_gnt = alu_win;
  assign bus.ld_gnt = ld_win;
  assign bus.busy = ~idle;
  assign bus.stk_full = ptr == PMAX;
  assign bus.stk_empty = ptr == '0;
  assign {bus.sr_v, bus.sr_n, bus.sr_z, bus.sr_c} = sr_q;
  assign bus.sr_ws = ws_q;
  assign bus.ie_ack = ie_ack_q;
  assign bus.ix_ack = ix_ack_q;
  assign bus.stk_err = err_q;
  always_comb begin
    state_nxt = state;
    ptr_nxt = ptr;
    sr_nxt = sr_q;
    ws_nxt = 1'b0;
    ie_ack_nxt = 1'b0;
    ix_ack_nxt = 1'b0;
    err_set = 2'b00;
    push = 1'b0;
    case (state)
      IDLE: begin
        if (ix) begin
          err_set[0] = bus.stk_empty;
          ix_ack_nxt = bus.stk_empty;
          state_nxt = bus.stk_empty ? IDLE : RESTORE;
        end else if (ie) begin
          err_set[1] = bus.stk_full;
          ie_ack_nxt = bus.stk_full;
          state_nxt = bus.stk_full ? IDLE : SAVE;
        end else if (ld_win | alu_win) begin
          ws_nxt = 1'b1;
          sr_nxt = ld_win ? bus.ld_flags : alu_val;
        end
      end
      SAVE: begin
        push = 1'b1;
        ptr_nxt = ptr + ONE;
        state_nxt = CLEAR;
      end
      CLEAR: begin
        sr_nxt = 4'b0000;
        ws_nxt = 1'b1;
        ie_ack_nxt = 1'b1;
        state_nxt = ACK;
      end
      RESTORE: begin
        ptr_nxt = ptr - ONE;
        sr_nxt = stack[top_idx];
        ws_nxt = 1'b1;
        ix_ack_nxt = 1'b1;
        state_nxt = ACK;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      sr_q <= 4'b0000;
      ws_q <= 1'b0;
      ie_ack_q <= 1'b0;
      ix_ack_q <= 1'b0;
      err_q <= 2'b00;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      sr_q <= sr_nxt;
      ws_q <= ws_nxt;
      ie_ack_q <= ie_ack_nxt;
      ix_ack_q <= ix_ack_nxt;
      err_q <= (err_q & {2{~bus.err_clr}}) | err_set;
    end
  end
  always_ff @(posedge clk)
    if (push) stack[ptr[PTRW-1:0]] <= bus.sr_in;
endmodule

// File: tb/tb_sr_ctrl.sv
// tb_sr_ctrl: directed self-checking bench for sr_ctrl
module tb_sr_ctrl;
  logic clk, reset;
  int total, bad;
  logic [3:0] sr_o;
  sr_ctrl_if bus();
  sr_ctrl #(.DEPTH(4), .PTRW(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign sr_o = {bus.sr_v, bus.sr_n, bus.sr_z, bus.sr_c};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    tick;
    tick;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.stk_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", bus.stk_empty); end
    total++; if (bus.stk_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", bus.stk_full); end
    total++; if (bus.sr_ws !== 1'b0) begin bad++; $display("FAIL rst_ws got=%b exp=0", bus.sr_ws); end
    total++; if (sr_o !== 4'b0000) begin bad++; $display("FAIL rst_sr got=%b exp=0000", sr_o); end
    total++; if (bus.stk_err !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", bus.stk_err); end
    total++; if ({bus.ie_ack, bus.ix_ack} !== 2'b00) begin bad++; $display("FAIL rst_ack got=%b exp=00", {bus.ie_ack, bus.ix_ack}); end
    reset = 1'b1;
    tick;
  endtask
  task automatic test_alu;
    bus.alu_req = 1'b1;
    bus.alu_flags = 4'b1010;
    #1;
    total++; if (bus.alu_gnt !== 1'b1) begin bad++; $display("FAIL alu_gnt got=%b exp=1", bus.alu_gnt); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL alu_busy got=%b exp=0", bus.busy); end
    tick;
    bus.alu_req = 1'b0;
    #1;
    total++; if (bus.sr_ws !== 1'b1) begin bad++; $display("FAIL alu_ws got=%b exp=1", bus.sr_ws); end
    total++; if (sr_o !== 4'b1010) begin bad++; $display("FAIL alu_sr got=%b exp=1010", sr_o); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL alu_busy2 got=%b exp=0", bus.busy); end
    tick;
    total++; if (bus.sr_ws !== 1'b0) begin bad++; $display("FAIL alu_ws_low got=%b exp=0", bus.sr_ws); end
  endtask
  task automatic test_priority;
    bus.ld_req = 1'b1;
    bus.ld_flags = 4'b0110;
    bus.alu_req = 1'b1;
    bus.alu_flags = 4'b0011;
    #1;
    total++; if (bus.ld_gnt !== 1'b1) begin bad++; $display("FAIL pri_ld_gnt got=%b exp=1", bus.ld_gnt); end
    total++; if (bus.alu_gnt !== 1'b0) begin bad++; $display("FAIL pri_alu_held got=%b exp=0", bus.alu_gnt); end
    tick;
    bus.ld_req = 1'b0;
    #1;
    total++; if (bus.sr_ws !== 1'b1) begin bad++; $display("FAIL pri_ld_ws got=%b exp=1", bus.sr_ws); end
    total++; if (sr_o !== 4'b0110) begin bad++; $display("FAIL pri_ld_sr got=%b exp=0110", sr_o); end
    total++; if (bus.alu_gnt !== 1'b1) begin bad++; $display("FAIL pri_alu_gnt got=%b exp=1", bus.alu_gnt); end
    tick;
    bus.alu_req = 1'b0;
    total++; if (sr_o !== 4'b0011) begin bad++; $display("FAIL pri_alu_sr got=%b exp=0011", sr_o); end
    tick;
  endtask
  task automatic test_back_to_back;
    logic [3:0] f [3];
    f[0] = 4'b0001; f[1] = 4'b0010; f[2] = 4'b0100;
    bus.alu_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.alu_flags = f[i];
      #1;
      total++; if (bus.alu_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt[%0d] got=%b exp=1", i, bus.alu_gnt); end
      tick;
      total++; if (sr_o !== f[i] || bus.sr_ws !== 1'b1) begin bad++; $display("FAIL b2b_sr[%0d] got=%b ws=%b exp=%b ws=1", i, sr_o, bus.sr_ws, f[i]); end
    end
    bus.alu_req = 1'b0;
    tick;
  endtask
  task automatic test_ie_ix;
    bus.sr_in = 4'b1101;
    bus.ie_req = 1'b1;
    bus.alu_req = 1'b1;
    #1;
    total++; if (bus.alu_gnt !== 1'b0) begin bad++; $display("FAIL ie_blocks_alu got=%b exp=0", bus.alu_gnt); end
    tick;
    total++; if (bus.busy !== 1'b1 || bus.sr_ws !== 1'b0) begin bad++; $display("FAIL ie_save busy=%b ws=%b exp busy=1 ws=0", bus.busy, bus.sr_ws); end
    total++; if (bus.alu_gnt !== 1'b0) begin bad++; $display("FAIL ie_busy_alu got=%b exp=0", bus.alu_gnt); end
    tick;
    total++; if (bus.sr_ws !== 1'b0 || bus.stk_empty !== 1'b0) begin bad++; $display("FAIL ie_clear ws=%b empty=%b exp ws=0 empty=0", bus.sr_ws, bus.stk_empty); end
    tick;
    total++; if (bus.sr_ws !== 1'b1 || sr_o !== 4'b0000 || bus.ie_ack !== 1'b1) begin bad++; $display("FAIL ie_ack ws=%b sr=%b ack=%b exp ws=1 sr=0000 ack=1", bus.sr_ws, sr_o, bus.ie_ack); end
    bus.ie_req = 1'b0;
    bus.alu_req = 1'b0;
    tick;
    total++; if (bus.ie_ack !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL ie_done ack=%b busy=%b exp 0 0", bus.ie_ack, bus.busy); end
    bus.sr_in = 4'b0000;
    bus.ix_req = 1'b1;
    tick;
    total++; if (bus.busy !== 1'b1 || bus.sr_ws !== 1'b0) begin bad++; $display("FAIL ix_restore busy=%b ws=%b exp busy=1 ws=0", bus.busy, bus.sr_ws); end
    tick;
    total++; if (bus.sr_ws !== 1'b1 || sr_o !== 4'b1101 || bus.ix_ack !== 1'b1) begin bad++; $display("FAIL ix_ack ws=%b sr=%b ack=%b exp ws=1 sr=1101 ack=1", bus.sr_ws, sr_o, bus.ix_ack); end
    total++; if (bus.stk_empty !== 1'b1) begin bad++; $display("FAIL ix_empty got=%b exp=1", bus.stk_empty); end
    bus.ix_req = 1'b0;
    tick;
    total++; if (bus.ix_ack !== 1'b0 || bus.sr_ws !== 1'b0) begin bad++; $display("FAIL ix_done ack=%b ws=%b exp 0 0", bus.ix_ack, bus.sr_ws); end
  endtask
  task automatic test_nested;
    logic [3:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 4'b0001 << i;
      bus.sr_in = v;
      bus.ie_req = 1'b1;
      tick;
      tick;
      tick;
      total++; if (bus.ie_ack !== 1'b1 || bus.sr_ws !== 1'b1) begin bad++; $display("FAIL nest_push[%0d] ack=%b ws=%b exp 1 1", i, bus.ie_ack, bus.sr_ws); end
      bus.ie_req = 1'b0;
      tick;
    end
    total++; if (bus.stk_full !== 1'b1) begin bad++; $display("FAIL nest_full got=%b exp=1", bus.stk_full); end
    bus.sr_in = 4'b1111;
    bus.ie_req = 1'b1;
    tick;
    total++; if (bus.ie_ack !== 1'b1 || bus.sr_ws !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL ovf ack=%b ws=%b busy=%b exp 1 0 0", bus.ie_ack, bus.sr_ws, bus.busy); end
    total++; if (bus.stk_err !== 2'b10) begin bad++; $display("FAIL ovf_err got=%b exp=10", bus.stk_err); end
    bus.ie_req = 1'b0;
    tick;
    total++; if (bus.ie_ack !== 1'b0 || bus.stk_full !== 1'b1) begin bad++; $display("FAIL ovf_after ack=%b full=%b exp 0 1", bus.ie_ack, bus.stk_full); end
    for (int i = 0; i < 4; i++) begin
      v = 4'b1000 >> i;
      bus.ix_req = 1'b1;
      tick;
      tick;
      total++; if (sr_o !== v || bus.sr_ws !== 1'b1 || bus.ix_ack !== 1'b1) begin bad++; $display("FAIL nest_pop[%0d] sr=%b ws=%b ack=%b exp sr=%b ws=1 ack=1", i, sr_o, bus.sr_ws, bus.ix_ack, v); end
      bus.ix_req = 1'b0;
      tick;
    end
    total++; if (bus.stk_empty !== 1'b1) begin bad++; $display("FAIL nest_empty got=%b exp=1", bus.stk_empty); end
    bus.err_clr = 1'b1;
    tick;
    bus.err_clr = 1'b0;
    total++; if (bus.stk_err !== 2'b00) begin bad++; $display("FAIL ovf_clr got=%b exp=00", bus.stk_err); end
  endtask
  task automatic test_underflow;
    bus.ix_req = 1'b1;
    tick;
    total++; if (bus.ix_ack !== 1'b1 || bus.sr_ws !== 1'b0 || bus.stk_err !== 2'b01) begin bad++; $display("FAIL udf ack=%b ws=%b err=%b exp 1 0 01", bus.ix_ack, bus.sr_ws, bus.stk_err); end
    bus.ix_req = 1'b0;
    tick;
    total++; if (bus.ix_ack !== 1'b0 || bus.stk_err !== 2'b01) begin bad++; $display("FAIL udf_sticky ack=%b err=%b exp 0 01", bus.ix_ack, bus.stk_err); end
    bus.err_clr = 1'b1;
    tick;
    total++; if (bus.stk_err !== 2'b00) begin bad++; $display("FAIL udf_clr got=%b exp=00", bus.stk_err); end
    bus.ix_req = 1'b1;
    tick;
    total++; if (bus.stk_err !== 2'b01) begin bad++; $display("FAIL set_wins got=%b exp=01", bus.stk_err); end
    bus.ix_req = 1'b0;
    tick;
    bus.err_clr = 1'b0;
    total++; if (bus.stk_err !== 2'b00) begin bad++; $display("FAIL clr2 got=%b exp=00", bus.stk_err); end
  endtask
  task automatic test_reset_mid;
    bus.sr_in = 4'b0101;
    bus.ie_req = 1'b1;
    tick;
    tick;
    total++; if (bus.busy !== 1'b1 || sr_o !== 4'b0001) begin bad++; $display("FAIL mid_pre busy=%b sr=%b exp 1 0001", bus.busy, sr_o); end
    reset = 1'b0;
    tick;
    total++; if (bus.sr_ws !== 1'b0 || bus.ie_ack !== 1'b0 || sr_o !== 4'b0000) begin bad++; $display("FAIL mid_rst ws=%b ack=%b sr=%b exp 0 0 0000", bus.sr_ws, bus.ie_ack, sr_o); end
    total++; if (bus.stk_empty !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL mid_state empty=%b busy=%b exp 1 0", bus.stk_empty, bus.busy); end
    bus.ie_req = 1'b0;
    reset = 1'b1;
    tick;
    total++; if (bus.ie_ack !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL mid_after ack=%b busy=%b exp 0 0", bus.ie_ack, bus.busy); end
  endtask
  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    bus.alu_req = 1'b0; bus.alu_flags = 4'b0000;
    bus.ld_req = 1'b0; bus.ld_flags = 4'b0000;
    bus.ie_req = 1'b0; bus.ix_req = 1'b0;
    bus.sr_in = 4'b0000; bus.err_clr = 1'b0;
`ifdef SRCTRL_ALU_MASK_EN
    bus.alu_mask = 4'b1111;
`endif
    test_reset;
    test_alu;
    test_priority;
    test_back_to_back;
    test_ie_ix;
    test_nested;
    test_underflow;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sr_ctrl.md
Name: sr_ctrl

Overview:
Write controller for the 4-bit status register {v,n,z,c}. It arbitrates SR writes between the ALU flag-update path, software SR loads and interrupt entry/exit. Interrupt entry pushes the current SR onto a shadow stack and then clears it; interrupt exit pops the stack back into the SR. It drives the SR flag inputs and ws strobe, and sits between the control unit/ALU and the SR.

Parameters:
DEPTH, 4, shadow stack entries (power of 2, >=2)
PTRW, 2, stack pointer width, log2(DEPTH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
alu_req  in  1  ALU requests flag update
alu_flags  in  4  ALU flags {v,n,z,c}
alu_gnt  out  1  ALU request accepted this cycle
ld_req  in  1  software SR load request
ld_flags  in  4  value to load {v,n,z,c}
ld_gnt  out  1  load accepted this cycle
ie_req  in  1  interrupt-entry request (level, held until ie_ack)
ix_req  in  1  interrupt-exit request (level, held until ix_ack)
ie_ack  out  1  one-cycle pulse, entry sequence complete
ix_ack  out  1  one-cycle pulse, exit sequence complete
sr_in  in  4  current SR contents {v,n,z,c}
sr_v, sr_n, sr_z, sr_c  out  1 each  flag values to SR
sr_ws  out  1  SR write strobe
busy  out  1  FSM not in IDLE
stk_full  out  1  shadow stack holds DEPTH entries
stk_empty  out  1  shadow stack empty
stk_err  out  2  sticky {overflow, underflow}
err_clr  in  1  clears stk_err

Behaviour:
- Reset (reset==0 at posedge): FSM=IDLE, stack pointer=0, sr_v/n/z/c=0, sr_ws=0, ie_ack=ix_ack=0, stk_err=00. busy=0, stk_empty=1, stk_full=0. Stack contents undefined.
- Reset mid-sequence aborts the sequence. No ack issued. Requesters re-request.
- sr_v..sr_c, sr_ws, ie_ack, ix_ack are registered. alu_gnt, ld_gnt, busy, stk_full, stk_empty are combinational from state/pointer.
- IDLE priority, highest first: ix_req, ie_req, ld_req, alu_req. One winner per cycle. Losers are held off and keep requesting.
- ALU/load: in IDLE with the winning request, gnt=1 the same cycle. Next cycle sr_ws=1 with flags = captured data, so the SR updates 2 edges after request. Back-to-back grants are allowed every cycle.
- alu_gnt and ld_gnt are 0 whenever state != IDLE or a higher-priority request is present.
- FSM states: IDLE, SAVE, CLEAR, RESTORE, ACK.
  - ie_req in IDLE, stack not full -> SAVE.
  - SAVE: push sr_in at stack[ptr], ptr+1, sr_ws=0 -> CLEAR.
  - CLEAR: register sr_*=0000, sr_ws=1 next cycle -> ACK (ie_ack=1) -> IDLE.
  - ix_req in IDLE, stack not empty -> RESTORE.
  - RESTORE: ptr-1, register popped value onto sr_*, sr_ws=1 next cycle -> ACK (ix_ack=1) -> IDLE.
- ie_req with stk_full: no push, no SR write. stk_err[1] set, ie_ack pulses next cycle, stays IDLE.
- ix_req with stk_empty: no pop, no SR write. stk_err[0] set, ix_ack pulses next cycle, stays IDLE.
- Requester must drop its request on the cycle ack is seen. The controller ignores a request in the cycle ack is high.
- stk_err is sticky until err_clr=1 or reset. If an error sets in the same cycle as err_clr, the set wins.
- The pointer never wraps: saturated by the full/empty checks.
- sr_ws is low in every cycle not listed above.

Optional Feature:
SRCTRL_ALU_MASK_EN
- Defined: adds input alu_mask[3:0]. On an ALU write, bit i = alu_mask[i] ? alu_flags[i] : sr_in[i], with sr_in sampled in the grant cycle. alu_mask=0000 still grants and still writes, leaving the SR unchanged.
- Undefined: no alu_mask port. All four flags are written from alu_flags.

Test Plan:
- Reset, then alu_req=1, alu_flags=1010 -> alu_gnt same cycle; next cycle sr_ws=1, {v,n,z,c}=1010; busy=0 throughout.
- ld_req and alu_req both high, ld_flags=0110 -> ld_gnt=1, alu_gnt=0; next cycle sr_*=0110; alu granted the following cycle.
- sr_in=1101, ie_req -> SAVE, CLEAR (sr_ws=1, 0000), ie_ack pulse, stk_empty=0. Then ix_req -> sr_ws=1 with 1101, ix_ack, stk_empty=1.
- DEPTH=4: four nested entries with distinct sr_in (0001, 0010, 0100, 1000) -> stk_full=1. Fifth ie_req -> stk_err=10, no sr_ws, ie_ack. Four exits restore 1000, 0100, 0010, 0001 in that order.
- ix_req on empty stack -> stk_err=01, ix_ack, no sr_ws. err_clr -> stk_err=00.
- reset low during CLEAR -> all outputs zero next cycle, no ie_ack, stk_empty=1.
